// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer read path.
package fb_pkg;

  localparam int unsigned HDISP_DEF = 800;
  localparam int unsigned VDISP_DEF = 480;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [23:0] rgb;
  } pix_t;

  typedef enum logic [1:0] {
    RUN,
    ABORT,
    FLUSH
  } state_t;

endpackage

// File: rtl/wshb_if.sv
// 32-bit Wishbone bus bundle with master and slave views.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;

  modport master (
    input  clk, rst,
    output adr, cyc, stb, we, sel, cti, bte, dat_ms,
    input  dat_sm, ack
  );

  modport slave (
    input  clk, rst,
    input  adr, cyc, stb, we, sel, cti, bte, dat_ms,
    output dat_sm, ack
  );

endinterface

// File: rtl/fb_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout while not empty.
module fb_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full && !clear;
  assign rd_en = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Zero while empty so the stream fields read 0 out of reset.
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fb_reader.sv
// Wishbone read master streaming the framebuffer in raster order through a FIFO.
module fb_reader
  import fb_pkg::*;
#(
  parameter int unsigned HDISP      = HDISP_DEF,
  parameter int unsigned VDISP      = VDISP_DEF,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  wshb_if.master      wshb_ifm,
  input  logic        restart,
  output logic [23:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state;
  state_t        state_next;
  logic          req;
  logic          req_next;
  logic [XW-1:0] rx;
  logic [YW-1:0] ry;
  logic [31:0]   adr;
  logic          last_x;
  logic          last_y;
  logic          ack_hit;
  logic          push;
  logic          pop;
  logic          clear;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          full;
  pix_t          wr_pix;
  pix_t          rd_pix;

  assign wshb_ifm.cyc    = req;
  assign wshb_ifm.stb    = req;
  assign wshb_ifm.adr    = adr;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = '1;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;
  assign wshb_ifm.dat_ms = '0;

  assign last_x  = (rx == XW'(HDISP - 1));
  assign last_y  = (ry == YW'(VDISP - 1));
  assign ack_hit = req && wshb_ifm.ack;

  // An ack coinciding with restart is dropped rather than pushed.
  assign push  = (state == RUN) && !restart && ack_hit;
  assign clear = (state == FLUSH);

  assign pix_valid = !empty && (state != FLUSH);
  assign pop       = pix_valid && pix_ready;

  assign count_next = count + CW'(push) - CW'(pop);

  assign wr_pix.sof = (rx == '0) && (ry == '0);
  assign wr_pix.eol = last_x;
  assign wr_pix.rgb = wshb_ifm.dat_sm[23:0];

  assign pix_data = rd_pix.rgb;
  assign pix_sof  = rd_pix.sof;
  assign pix_eol  = rd_pix.eol;

  always_comb begin
    state_next = state;
    req_next   = req;
    case (state)
      RUN: begin
        if (restart) begin
          // A pending cycle must complete on the bus before it can be dropped.
          if (req && !wshb_ifm.ack) begin
            state_next = ABORT;
          end else begin
            state_next = FLUSH;
            req_next   = 1'b0;
          end
        end else begin
          req_next = (count_next < CW'(FIFO_DEPTH - 1));
        end
      end
      ABORT: begin
        if (ack_hit) begin
          state_next = FLUSH;
          req_next   = 1'b0;
        end
      end
      FLUSH: begin
        state_next = RUN;
        req_next   = 1'b1;
      end
      default: begin
        state_next = RUN;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      req   <= 1'b0;
    end else begin
      state <= state_next;
      req   <= req_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx  <= '0;
      ry  <= '0;
      adr <= BASE_ADDR;
    end else if (clear) begin
      rx  <= '0;
      ry  <= '0;
      adr <= BASE_ADDR;
    end else if (push) begin
      if (last_x) begin
        rx <= '0;
        if (last_y) begin
          ry  <= '0;
          adr <= BASE_ADDR;
        end else begin
          ry  <= ry + YW'(1);
          adr <= adr + 32'd4;
        end
      end else begin
        rx  <= rx + XW'(1);
        adr <= adr + 32'd4;
      end
    end
  end

  fb_fifo #(
    .WIDTH ($bits(pix_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (wr_pix),
    .pop   (pop),
    .dout  (rd_pix),
    .count (count),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on an 8x4 frame with an 8-entry FIFO.
module tb_fb_reader;

  localparam int unsigned HD    = 8;
  localparam int unsigned VD    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int          FRAME = HD * VD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        pix_ready = 1'b0;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned ack_delay = 1;
  int unsigned wait_cnt  = 0;

  logic [25:0] got[$];
  int          seg_start = 0;
  int          checked   = 0;

  always #5 clk = ~clk;

  wshb_if wshb (.clk(clk), .rst(!rst_n));

  fb_reader #(
    .HDISP      (HD),
    .VDISP      (VD),
    .BASE_ADDR  (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wshb_ifm  (wshb.master),
    .restart   (restart),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  // Memory model: returns the address as data, acks ack_delay cycles after stb.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wshb.ack    <= 1'b0;
      wshb.dat_sm <= '0;
      wait_cnt    <= 0;
    end else if (wshb.ack) begin
      wshb.ack <= 1'b0;
      wait_cnt <= 0;
    end else if (wshb.cyc && wshb.stb) begin
      if (wait_cnt + 1 >= ack_delay) begin
        wshb.ack    <= 1'b1;
        wshb.dat_sm <= wshb.adr;
        wait_cnt    <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && pix_valid && pix_ready) got.push_back({pix_sof, pix_eol, pix_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pixels(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      tick();
      c++;
    end
    check_eq("wait_pixels", 32'(got.size() >= n), 32'd1);
  endtask

  // Pixels from seg_start on are expected to be a raster sequence from (0,0).
  task automatic check_stream(input int upto);
    for (int i = checked; i < upto; i++) begin
      int          k;
      logic [25:0] e;
      k = (i - seg_start) % FRAME;
      e = got[i];
      check_eq($sformatf("px%0d_data", i), {8'h0, e[23:0]}, 32'(k * 4));
      check_eq($sformatf("px%0d_sof", i), 32'(e[25]), 32'(k == 0));
      check_eq($sformatf("px%0d_eol", i), 32'(e[24]), 32'((k % HD) == HD - 1));
    end
    checked = upto;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    bit          found;
    bit          fell;

    // 1. reset values and first read
    #12;
    check_eq("rst_cyc", 32'(wshb.cyc), 32'd0);
    check_eq("rst_stb", 32'(wshb.stb), 32'd0);
    check_eq("rst_adr", wshb.adr, 32'h0);
    check_eq("rst_valid", 32'(pix_valid), 32'd0);
    check_eq("rst_data", 32'(pix_data), 32'd0);
    check_eq("rst_sof", 32'(pix_sof), 32'd0);
    check_eq("rst_eol", 32'(pix_eol), 32'd0);
    check_eq("const_we", 32'(wshb.we), 32'd0);
    check_eq("const_sel", 32'(wshb.sel), 32'hf);
    check_eq("const_cti", 32'(wshb.cti), 32'd0);
    check_eq("const_bte", 32'(wshb.bte), 32'd0);
    check_eq("const_dat_ms", wshb.dat_ms, 32'h0);

    @(negedge clk);
    rst_n     = 1'b1;
    pix_ready = 1'b1;
    tick();
    check_eq("first_stb", 32'(wshb.stb), 32'd1);
    check_eq("first_cyc", 32'(wshb.cyc), 32'd1);
    check_eq("first_adr", wshb.adr, 32'h0);
    wait_pixels(1, 20);
    check_stream(1);

    // 2. full frame plus wrap
    wait_pixels(FRAME + 1, 200);
    check_stream(FRAME + 1);

    // 3. backpressure
    pix_ready = 1'b0;
    fell = 1'b0;
    repeat (30) begin
      tick();
      if (!fell && !wshb.stb) begin
        fell = 1'b1;
        check_eq("bp_count_at_fall", 32'(dut.u_fifo.count), 32'd7);
      end
    end
    check_eq("bp_stb_fell", 32'(fell), 32'd1);
    check_eq("bp_stb_low", 32'(wshb.stb), 32'd0);
    check_eq("bp_count_hold", 32'(dut.u_fifo.count), 32'd7);
    check_eq("bp_valid", 32'(pix_valid), 32'd1);
    check_eq("bp_head", 32'(pix_data), 32'(((got.size() - seg_start) % FRAME) * 4));
    pix_ready = 1'b1;
    wait_pixels(got.size() + 20, 200);
    check_stream(got.size());

    // 4. restart while a slow transfer is pending
    ack_delay = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (wshb.stb && !wshb.ack && wait_cnt == 0) found = 1'b1;
    end
    check_eq("t4_found", 32'(found), 32'd1);
    held    = wshb.adr;
    restart = 1'b1;
    tick();
    check_eq("t4_abort_stb", 32'(wshb.stb), 32'd1);
    check_eq("t4_abort_adr1", wshb.adr, held);
    check_eq("t4_abort_noack", 32'(wshb.ack), 32'd0);
    tick();
    restart = 1'b0;
    check_eq("t4_abort_adr2", wshb.adr, held);
    tick();
    check_eq("t4_ack", 32'(wshb.ack), 32'd1);
    check_eq("t4_abort_adr3", wshb.adr, held);
    tick();
    check_eq("t4_flush_stb", 32'(wshb.stb), 32'd0);
    check_eq("t4_flush_cyc", 32'(wshb.cyc), 32'd0);
    check_eq("t4_flush_valid", 32'(pix_valid), 32'd0);
    check_stream(got.size());
    seg_start = got.size();
    checked   = seg_start;
    ack_delay = 1;
    tick();
    check_eq("t4_new_stb", 32'(wshb.stb), 32'd1);
    check_eq("t4_new_adr", wshb.adr, 32'h0);
    wait_pixels(seg_start + 1, 40);
    check_stream(seg_start + 1);

    // 5. restart in the ack cycle of adr 40
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (wshb.ack && wshb.adr == 32'd40) found = 1'b1;
    end
    check_eq("t5_found", 32'(found), 32'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check_eq("t5_flush_stb", 32'(wshb.stb), 32'd0);
    check_eq("t5_flush_valid", 32'(pix_valid), 32'd0);
    check_stream(got.size());
    check_eq("t5_old_count", 32'(got.size() - seg_start), 32'd10);
    seg_start = got.size();
    checked   = seg_start;
    tick();
    check_eq("t5_new_stb", 32'(wshb.stb), 32'd1);
    check_eq("t5_new_adr", wshb.adr, 32'h0);
    wait_pixels(seg_start + 12, 100);
    check_stream(seg_start + 12);

    // 6. asynchronous reset mid-transfer
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (wshb.cyc) found = 1'b1;
    end
    check_eq("t6_found", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_cyc", 32'(wshb.cyc), 32'd0);
    check_eq("t6_stb", 32'(wshb.stb), 32'd0);
    check_eq("t6_valid", 32'(pix_valid), 32'd0);
    check_eq("t6_adr", wshb.adr, 32'h0);
    @(negedge clk);
    seg_start = got.size();
    checked   = seg_start;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("t6_new_stb", 32'(wshb.stb), 32'd1);
    check_eq("t6_new_adr", wshb.adr, 32'h0);
    wait_pixels(seg_start + 4, 40);
    check_stream(seg_start + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
